// File: rtl/bitstream_loader.sv
// Word-stream to serial configuration sequencer for the core programming port.
// Define BITSTREAM_LOADER_CHECKSUM_EN to require a trailing modulo checksum word.
module bitstream_loader #(
  parameter int BITS         = 10080,
  parameter int WORD_W       = 8,
  parameter int RESET_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WORD_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       cfg_dta,
  output logic                       cfg_den,
  output logic                       cfg_lut_reset,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(BITS+1)-1:0]  bit_count
);

  localparam int CW     = $clog2(BITS + 1);
  localparam int NWORDS = (BITS + WORD_W - 1) / WORD_W;
`ifdef BITSTREAM_LOADER_CHECKSUM_EN
  localparam int LIMIT  = NWORDS + 1;
`else
  localparam int LIMIT  = NWORDS;
`endif
  localparam int WCW    = $clog2(LIMIT + 1);
  localparam int KW     = $clog2(WORD_W + 1);
  localparam int RCW    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LUTRST,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WORD_W-1:0] shreg;
  logic [KW-1:0]     cnt;
  logic [WCW-1:0]    words;
  logic [RCW-1:0]    rcnt;

  logic take, load, shift_en, last_bit;
  logic fin, sum_ok, rst_last, kill, go;

  assign take     = in_valid && in_ready;
  assign shift_en = (cnt != '0) && (bit_count != CW'(BITS));
  assign last_bit = shift_en && (bit_count == CW'(BITS - 1));
  assign rst_last = (rcnt == RCW'(RESET_CYCLES - 1));
  assign kill     = abort && busy;
  assign go       = start && !abort;

`ifdef BITSTREAM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum;
  logic              csum_got;
  logic              csum_ok;
  logic              is_sum;

  // The word after the last data word is the checksum; it is never shifted.
  assign is_sum = take && (words == WCW'(NWORDS));
  assign load   = take && !is_sum;
  assign fin    = (bit_count == CW'(BITS)) && csum_got;
  assign sum_ok = csum_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum     <= '0;
      csum_got <= 1'b0;
      csum_ok  <= 1'b0;
    end else if ((state == IDLE || state == DONE) && go) begin
      csum     <= '0;
      csum_got <= 1'b0;
      csum_ok  <= 1'b0;
    end else if (state == SHIFT && take) begin
      if (is_sum) begin
        csum_got <= 1'b1;
        csum_ok  <= (csum == in_data);
      end else begin
        csum <= csum + in_data;
      end
    end
  end
`else
  assign load   = take;
  assign fin    = (bit_count == CW'(BITS));
  assign sum_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (go) state_nxt = SHIFT;
      SHIFT: begin
        if (abort)    state_nxt = IDLE;
        else if (fin) state_nxt = sum_ok ? LUTRST : DONE;
      end
      LUTRST: begin
        if (abort)         state_nxt = IDLE;
        else if (rst_last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    in_ready = 1'b0;
    unique case (1'b1)
      (state == SHIFT): begin
        busy     = 1'b1;
        in_ready = (cnt <= KW'(1)) && (words < WCW'(LIMIT));
      end
      (state == LUTRST): busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg         <= '0;
      cnt           <= '0;
      words         <= '0;
      rcnt          <= '0;
      bit_count     <= '0;
      cfg_dta       <= 1'b0;
      cfg_den       <= 1'b0;
      cfg_lut_reset <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else if (kill) begin
      shreg         <= '0;
      cnt           <= '0;
      cfg_den       <= 1'b0;
      cfg_lut_reset <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (go) begin
            shreg     <= '0;
            cnt       <= '0;
            words     <= '0;
            rcnt      <= '0;
            bit_count <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
          end
        end
        SHIFT: begin
          cfg_den <= shift_en;
          if (shift_en) begin
            cfg_dta   <= shreg[0];
            shreg     <= shreg >> 1;
            cnt       <= cnt - 1'b1;
            bit_count <= bit_count + 1'b1;
          end
          // Bits left in the buffer past the final bit are dropped.
          if (last_bit) cnt <= '0;
          if (load) begin
            shreg <= in_data;
            cnt   <= KW'(WORD_W);
          end
          if (take) words <= words + 1'b1;
          if (fin) begin
            if (sum_ok) begin
              cfg_lut_reset <= 1'b1;
              rcnt          <= '0;
            end else begin
              done  <= 1'b1;
              error <= 1'b1;
            end
          end
        end
        LUTRST: begin
          rcnt <= rcnt + 1'b1;
          if (rst_last) begin
            cfg_lut_reset <= 1'b0;
            done          <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_loader.sv
// Directed bench for bitstream_loader: full-size load plus a 20-bit
// instance for the partial-last-word and checksum cases.
module tb_bitstream_loader;

  localparam int BIG = 10080;
  localparam int SML = 20;

  logic       clk = 1'b0;
  logic       reset, start, abort, sel, in_valid;
  logic [7:0] in_data;

  logic        b_ready, b_dta, b_den, b_lut, b_busy, b_done, b_err;
  logic [13:0] b_bc;
  logic        s_ready, s_dta, s_den, s_lut, s_busy, s_done, s_err;
  logic [4:0]  s_bc;

  logic m_ready, m_dta, m_den, m_lut, m_busy, m_done, m_err;
  int   m_bc;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         dlog [0:BIG-1];
  int         den_cnt, gaps, gap_at, lut_cnt;
  logic       mon_clr;

  always #5 clk = ~clk;

  bitstream_loader #(.BITS(BIG), .WORD_W(8), .RESET_CYCLES(1)) u_big (
    .clk(clk), .reset(reset),
    .start(start && !sel), .abort(abort && !sel),
    .in_data(in_data), .in_valid(in_valid && !sel),
    .in_ready(b_ready), .cfg_dta(b_dta), .cfg_den(b_den),
    .cfg_lut_reset(b_lut), .busy(b_busy), .done(b_done),
    .error(b_err), .bit_count(b_bc)
  );

  bitstream_loader #(.BITS(SML), .WORD_W(8), .RESET_CYCLES(1)) u_small (
    .clk(clk), .reset(reset),
    .start(start && sel), .abort(abort && sel),
    .in_data(in_data), .in_valid(in_valid && sel),
    .in_ready(s_ready), .cfg_dta(s_dta), .cfg_den(s_den),
    .cfg_lut_reset(s_lut), .busy(s_busy), .done(s_done),
    .error(s_err), .bit_count(s_bc)
  );

  assign m_ready = sel ? s_ready : b_ready;
  assign m_dta   = sel ? s_dta   : b_dta;
  assign m_den   = sel ? s_den   : b_den;
  assign m_lut   = sel ? s_lut   : b_lut;
  assign m_busy  = sel ? s_busy  : b_busy;
  assign m_done  = sel ? s_done  : b_done;
  assign m_err   = sel ? s_err   : b_err;
  assign m_bc    = sel ? int'(s_bc) : int'(b_bc);

  always @(negedge clk) begin
    if (mon_clr) begin
      den_cnt = 0;
      gaps    = 0;
      gap_at  = -1;
      lut_cnt = 0;
    end else begin
      if (m_den) begin
        if (den_cnt < BIG) dlog[den_cnt] = m_dta;
        den_cnt++;
      end else if (m_busy && !m_lut && den_cnt > 0) begin
        if (gaps == 0) gap_at = den_cnt;
        gaps++;
      end
      if (m_lut) lut_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int from, input int stop_bits,
                      input int stall_w, input int stall_n,
                      output int upto);
    int w = from;
    int st = 0;
    int guard = 0;
    while (guard < 30000) begin
      if (w >= q.size() || m_bc >= stop_bits) break;
      if (w == stall_w && st < stall_n && m_ready) begin
        in_valid = 1'b0;
        st++;
      end else begin
        in_valid = 1'b1;
        in_data  = q[w];
        if (m_ready) w++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    chk("feed_in_time", guard < 30000, 1);
    upto = w;
  endtask

  task automatic wait_done(input int bound);
    int i = 0;
    while (!m_done && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk("done_in_time", m_done, 1);
  endtask

  function automatic int pat_err_01();
    int pe = 0;
    for (int i = 0; i < BIG; i++)
      if (dlog[i] !== (i % 8 == 0)) pe++;
    return pe;
  endfunction

  task automatic big_stream();
    q.delete();
    repeat (BIG / 8) q.push_back(8'h01);
`ifdef BITSTREAM_LOADER_CHECKSUM_EN
    q.push_back(8'hEC);
`endif
  endtask

  initial begin
    int w;
    int pe;
    int rdy_hi;
    logic [7:0] a5;
    reset = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0;
    in_valid = 1'b0; in_data = '0; mon_clr = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", m_ready, 0);
    chk("rst_dta", m_dta, 0);
    chk("rst_den", m_den, 0);
    chk("rst_lut", m_lut, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_error", m_err, 0);
    chk("rst_bc", m_bc, 0);
    chk("rst_small_bc", s_bc, 0);

    big_stream();
    clr();
    pulse_start();
    chk("nom_busy", m_busy, 1);
    feed(0, 1 << 30, -1, 0, w);
    wait_done(50);
    chk("nom_den_cnt", den_cnt, BIG);
    chk("nom_gaps", gaps, 0);
    chk("nom_lut_cycles", lut_cnt, 1);
    chk("nom_dta_pattern", pat_err_01(), 0);
    chk("nom_bc", m_bc, BIG);
    chk("nom_error", m_err, 0);
    chk("nom_busy_end", m_busy, 0);
    chk("nom_ready_end", m_ready, 0);
    chk("nom_lut_end", m_lut, 0);

    pulse_start();
    chk("restart_done", m_done, 0);
    chk("restart_busy", m_busy, 1);
    chk("restart_bc", m_bc, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("restart_abort_idle", m_busy, 0);

    clr();
    pulse_start();
    feed(0, 100, -1, 0, w);
    pulse_start();
    chk("busy_start_ignored", m_bc >= 100, 1);
    chk("busy_start_busy", m_busy, 1);
    feed(w, 300, -1, 0, w);
    chk("abort_at_bc", m_bc, 300);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_den", m_den, 0);
    chk("abort_busy", m_busy, 0);
    chk("abort_lut", m_lut, 0);
    repeat (5) @(negedge clk);
    chk("abort_no_lut", lut_cnt, 0);
    chk("abort_done", m_done, 0);
    chk("abort_den_cnt", den_cnt, 300);

    clr();
    pulse_start();
    feed(0, 500, -1, 0, w);
    chk("mid_bc", m_bc, 500);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_den", m_den, 0);
    chk("mid_rst_dta", m_dta, 0);
    chk("mid_rst_lut", m_lut, 0);
    chk("mid_rst_busy", m_busy, 0);
    chk("mid_rst_ready", m_ready, 0);
    chk("mid_rst_bc", m_bc, 0);
    clr();
    pulse_start();
    feed(0, 1 << 30, -1, 0, w);
    wait_done(50);
    chk("reload_den_cnt", den_cnt, BIG);
    chk("reload_bc", m_bc, BIG);
    chk("reload_lut", lut_cnt, 1);

    clr();
    pulse_start();
    feed(0, 1 << 30, 3, 5, w);
    wait_done(50);
    chk("stall_gaps", gaps, 5);
    chk("stall_gap_at", gap_at, 24);
    chk("stall_den_cnt", den_cnt, BIG);
    chk("stall_dta_pattern", pat_err_01(), 0);
    chk("stall_lut", lut_cnt, 1);

    sel = 1'b1;
    q.delete();
    q.push_back(8'hFF); q.push_back(8'h00); q.push_back(8'hA5);
`ifdef BITSTREAM_LOADER_CHECKSUM_EN
    q.push_back(8'hA4);
`endif
    clr();
    pulse_start();
    feed(0, 1 << 30, -1, 0, w);
    chk("part_words", w, q.size());
    rdy_hi = 0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      if (m_ready) rdy_hi++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("part_ready_low", rdy_hi, 0);
    wait_done(50);
    chk("part_den_cnt", den_cnt, SML);
    a5 = 8'hA5;
    pe = 0;
    for (int i = 0; i < SML; i++) begin
      if (i < 8 && dlog[i] !== 1'b1) pe++;
      if (i >= 8 && i < 16 && dlog[i] !== 1'b0) pe++;
      if (i >= 16 && dlog[i] !== a5[i-16]) pe++;
    end
    chk("part_pattern", pe, 0);
    chk("part_bit16", dlog[16], 1);
    chk("part_bit17", dlog[17], 0);
    chk("part_bit18", dlog[18], 1);
    chk("part_bit19", dlog[19], 0);
    chk("part_bc", m_bc, SML);
    chk("part_lut", lut_cnt, 1);
    chk("part_error", m_err, 0);

`ifdef BITSTREAM_LOADER_CHECKSUM_EN
    q[3] = 8'hA5;
    clr();
    pulse_start();
    feed(0, 1 << 30, -1, 0, w);
    wait_done(50);
    chk("bad_sum_error", m_err, 1);
    chk("bad_sum_done", m_done, 1);
    chk("bad_sum_no_lut", lut_cnt, 0);
    chk("bad_sum_den_cnt", den_cnt, SML);
    pulse_start();
    chk("bad_sum_err_clr", m_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
